mmio_timer: RTL and testbench

Memory-mapped 64-bit timer peripheral on the data-side MMIO path, in parallel with the L1 data cache. It decodes the EX-stage effective address and load/store types, and returns `d_valid`, `d_ready` and `d_rdata` to the MEM stage within the same cycle. It also produces a level interrupt that the top level routes into one bit of `interrupt_sources`.

---
 rtl/mmio_timer_pkg.sv | 22 ++
 rtl/mmio_timer_if.sv | 19 +
 rtl/mmio_timer_prescaler.sv | 23 ++
 rtl/mmio_timer.sv | 87 ++++++++
 tb/tb_mmio_timer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_timer_pkg.sv
// Shared constants for the MMIO timer: register selects, CTRL field positions, default base.
package mmio_timer_pkg;
    localparam logic [63:0] TIMER_BASE = 64'h0000_0000_2000_0000;

    localparam logic [1:0] TIMER_MTIME_OFF  = 2'd0;
    localparam logic [1:0] TIMER_CMP_OFF    = 2'd1;
    localparam logic [1:0] TIMER_CTRL_OFF   = 2'd2;
    localparam logic [1:0] TIMER_STATUS_OFF = 2'd3;

    localparam int TIMER_EN        = 0;
    localparam int TIMER_IE        = 1;
    localparam int TIMER_PERIODIC  = 2;
    localparam int TIMER_PRESC_LSB = 8;
    localparam int TIMER_PRESC_MSB = 15;

    // Only these CTRL bits are implemented; everything else reads back as zero.
    localparam logic [63:0] TIMER_CTRL_MASK = 64'h0000_0000_0000_FF07;

    function automatic logic timer_hit(input logic [63:0] addr, input logic [63:0] base);
        return addr[63:5] == base[63:5];
    endfunction
endpackage

// File: rtl/mmio_timer_if.sv
// Data-side MMIO access bundle: EX-stage address/data/type in, same-cycle response out.
interface mmio_timer_if;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  mem_load_type;
    logic [2:0]  mem_store_type;
    logic        d_valid;
    logic        d_ready;
    logic [63:0] d_rdata;

    modport master (
        output addr, wdata, mem_load_type, mem_store_type,
        input  d_valid, d_ready, d_rdata
    );
    modport slave (
        input  addr, wdata, mem_load_type, mem_store_type,
        output d_valid, d_ready, d_rdata
    );
endinterface

// File: rtl/mmio_timer_prescaler.sv
// Divide-by-(PRESC+1) tick generator; held at zero while disabled or being cleared.
module timer_prescaler (
    input  logic       clock,
    input  logic       reset,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic [7:0] presc_i,
    output logic       tick_o
);
    logic [7:0] pcnt_q, pcnt_d;

    assign tick_o = en_i && (pcnt_q == presc_i);

    always_comb begin
        pcnt_d = pcnt_q + 8'd1;
        if (clr_i || !en_i || tick_o) pcnt_d = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pcnt_q <= '0;
        else       pcnt_q <= pcnt_d;
    end
endmodule

// File: rtl/mmio_timer.sv
// 64-bit memory-mapped timer (MTIME, MTIMECMP, CTRL, STATUS) with a registered level interrupt.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = TIMER_BASE
) (
    input  logic        clock,
    input  logic        reset,
    mmio_timer_if.slave bus,
    output logic        irq
);
    logic        hit, is_ld, is_st, wr, ctrl_wr, tick, match;
    logic [1:0]  sel;
    logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d, ctrl_q, ctrl_d, rdata;
    logic        pend_q, pend_d, irq_q;
    logic        unused_lsb;

    assign hit        = timer_hit(bus.addr, BASE_ADDR);
    assign is_ld      = |bus.mem_load_type;
    assign is_st      = |bus.mem_store_type;
    assign sel        = bus.addr[4:3];
    assign unused_lsb = ^bus.addr[2:0];
    // A store wins over a simultaneous load, so the write strobe ignores the load type.
    assign wr         = hit & is_st;
    assign ctrl_wr    = wr && (sel == TIMER_CTRL_OFF);
    assign match      = mtime_q >= cmp_q;

    timer_prescaler u_presc (
        .clock   (clock),
        .reset   (reset),
        .en_i    (ctrl_q[TIMER_EN]),
        .clr_i   (ctrl_wr),
        .presc_i (ctrl_q[TIMER_PRESC_MSB:TIMER_PRESC_LSB]),
        .tick_o  (tick)
    );

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (sel)
                TIMER_MTIME_OFF: rdata = mtime_q;
                TIMER_CMP_OFF:   rdata = cmp_q;
                TIMER_CTRL_OFF:  rdata = ctrl_q;
                default:         rdata = {63'b0, pend_q};
            endcase
        end
    end

    assign bus.d_valid = hit;
    assign bus.d_ready = hit & (is_ld | is_st);
    assign bus.d_rdata = rdata;
    assign irq         = irq_q;

    always_comb begin
        mtime_d = mtime_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        pend_d  = pend_q;
        if (tick) mtime_d = (ctrl_q[TIMER_PERIODIC] && match) ? '0 : mtime_q + 64'd1;
        // Software writes override the tick; a live match overrides a W1C.
        if (wr) begin
            case (sel)
                TIMER_MTIME_OFF: mtime_d = bus.wdata;
                TIMER_CMP_OFF:   cmp_d   = bus.wdata;
                TIMER_CTRL_OFF:  ctrl_d  = bus.wdata & TIMER_CTRL_MASK;
                default:         if (bus.wdata[0]) pend_d = 1'b0;
            endcase
        end
        if (match) pend_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtime_q <= '0;
            cmp_q   <= '1;
            ctrl_q  <= '0;
            pend_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            pend_q  <= pend_d;
            irq_q   <= pend_q & ctrl_q[TIMER_IE];
        end
    end
endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: constant vector table, directed corner sequences, random traffic vs a cycle model.
module tb_mmio_timer;
    localparam logic [63:0] BASE = 64'h0000_0000_2000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clock = 1'b0;
    logic reset;
    logic irq;
    int   checks = 0;
    int   failures = 0;

    mmio_timer_if bus();
    mmio_timer #(.BASE_ADDR(BASE)) dut (.clock(clock), .reset(reset), .bus(bus), .irq(irq));

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Behavioural model: registers as plain numbers, prescaler as a cycle phase.
    logic [63:0] m_mtime, m_cmp;
    bit          m_en, m_ie, m_per, m_pend, m_irq;
    int          m_presc, m_phase;

    function automatic void model_reset();
        m_mtime = 0; m_cmp = ONES; m_en = 0; m_ie = 0; m_per = 0;
        m_presc = 0; m_phase = 0; m_pend = 0; m_irq = 0;
    endfunction

    function automatic bit in_win(input logic [63:0] a);
        return (a >> 5) == (BASE >> 5);
    endfunction

    function automatic logic [63:0] model_rd(input logic [63:0] a);
        logic [63:0] r;
        logic [1:0]  s;
        r = 0;
        s = a[4:3];
        if (in_win(a)) begin
            case (s)
                2'd0: r = m_mtime;
                2'd1: r = m_cmp;
                2'd2: r = 64'(m_presc) * 256 + 64'(m_per) * 4 + 64'(m_ie) * 2 + 64'(m_en);
                default: r = 64'(m_pend);
            endcase
        end
        return r;
    endfunction

    function automatic void model_step(input logic [2:0] ld, input logic [2:0] st,
                                       input logic [63:0] a, input logic [63:0] wd);
        bit          wr, tick, hitm, n_pend;
        logic [1:0]  s;
        logic [63:0] n_mtime, n_cmp;
        int          n_phase;
        wr    = in_win(a) && (st != 0);
        s     = a[4:3];
        tick  = m_en && (m_phase == m_presc);
        hitm  = m_mtime >= m_cmp;
        n_mtime = m_mtime;
        n_cmp   = m_cmp;
        n_pend  = m_pend;
        if (tick) n_mtime = (m_per && hitm) ? 64'd0 : m_mtime + 1;
        n_phase = m_en ? (m_phase + 1) % (m_presc + 1) : 0;
        m_irq = m_pend && m_ie;
        if (wr && s == 2'd0) n_mtime = wd;
        if (wr && s == 2'd1) n_cmp = wd;
        if (wr && s == 2'd3 && wd[0]) n_pend = 0;
        if (hitm) n_pend = 1;
        if (wr && s == 2'd2) begin
            m_en = wd[0]; m_ie = wd[1]; m_per = wd[2];
            m_presc = int'(wd[15:8]);
            n_phase = 0;
        end
        m_mtime = n_mtime; m_cmp = n_cmp; m_pend = n_pend; m_phase = n_phase;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] ld, input logic [2:0] st,
                         input logic [63:0] a, input logic [63:0] wd);
        @(negedge clock);
        bus.addr = a; bus.wdata = wd; bus.mem_load_type = ld; bus.mem_store_type = st;
        #1;
    endtask

    // One access cycle checked against the model, then the model advances past the edge.
    task automatic cyc(input logic [2:0] ld, input logic [2:0] st,
                       input logic [63:0] a, input logic [63:0] wd);
        drive(ld, st, a, wd);
        chk("valid", 64'(bus.d_valid), 64'(in_win(a)));
        chk("ready", 64'(bus.d_ready), 64'(in_win(a) && (ld != 0 || st != 0)));
        chk("rdata", bus.d_rdata, model_rd(a));
        chk("irq",   64'(irq), 64'(m_irq));
        model_step(ld, st, a, wd);
    endtask

    task automatic rd(input logic [63:0] off);  cyc(3'd1, 3'd0, BASE + off, 64'd0); endtask
    task automatic wr(input logic [63:0] off, input logic [63:0] v); cyc(3'd0, 3'd3, BASE + off, v); endtask

    task automatic do_reset();
        @(negedge clock);
        bus.mem_load_type = 0; bus.mem_store_type = 0; bus.addr = 0; bus.wdata = 0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    typedef struct {
        string       nm;
        logic [2:0]  ld, st;
        logic [63:0] off, wd;
        logic        ev, er;
        logic [63:0] erd;
    } vec_t;

    function automatic vec_t V(input string nm, input logic [2:0] ld, input logic [2:0] st,
                               input logic [63:0] off, input logic [63:0] wd,
                               input logic ev, input logic er, input logic [63:0] erd);
        vec_t v;
        v.nm = nm; v.ld = ld; v.st = st; v.off = off; v.wd = wd; v.ev = ev; v.er = er; v.erd = erd;
        return v;
    endfunction

    vec_t vt[26];

    initial begin
        logic [63:0] seq [8];
        logic [63:0] a, wd;
        logic [2:0]  ld, st;
        int          n;

        vt[0]  = V("rst_ctrl",     1, 0, 64'h10, 0,      1, 1, 0);
        vt[1]  = V("rst_cmp",      1, 0, 64'h08, 0,      1, 1, ONES);
        vt[2]  = V("past_window",  1, 0, 64'h20, 0,      0, 0, 0);
        vt[3]  = V("rst_mtime",    1, 0, 64'h00, 0,      1, 1, 0);
        vt[4]  = V("rst_status",   1, 0, 64'h18, 0,      1, 1, 0);
        vt[5]  = V("no_access",    0, 0, 64'h08, 0,      1, 0, ONES);
        vt[6]  = V("low_bits_ign", 2, 0, 64'h0F, 0,      1, 1, ONES);
        vt[7]  = V("wr_cmp",       0, 3, 64'h08, 64'h55, 1, 1, ONES);
        vt[8]  = V("rd_cmp",       1, 0, 64'h08, 0,      1, 1, 64'h55);
        vt[9]  = V("ldst_cmp",     4, 2, 64'h08, 64'h66, 1, 1, 64'h55);
        vt[10] = V("rd_cmp2",      1, 0, 64'h08, 0,      1, 1, 64'h66);
        vt[11] = V("wr_ctrl_ones", 0, 1, 64'h10, ONES,   1, 1, 0);
        vt[12] = V("rd_ctrl_mask", 1, 0, 64'h10, 0,      1, 1, 64'hFF07);
        vt[13] = V("wr_ctrl_0",    0, 1, 64'h10, 0,      1, 1, 64'hFF07);
        vt[14] = V("rd_ctrl_0",    1, 0, 64'h10, 0,      1, 1, 0);
        vt[15] = V("below_window", 1, 0, -64'sd8, 0,     0, 0, 0);
        vt[16] = V("wr_mtime",     0, 5, 64'h00, 64'h77, 1, 1, 0);
        vt[17] = V("rd_mtime",     1, 0, 64'h00, 0,      1, 1, 64'h77);
        vt[18] = V("pend_set",     1, 0, 64'h18, 0,      1, 1, 1);
        vt[19] = V("w1c_vs_match", 0, 1, 64'h18, 1,      1, 1, 1);
        vt[20] = V("set_wins",     1, 0, 64'h18, 0,      1, 1, 1);
        vt[21] = V("wr_cmp_ones",  0, 1, 64'h08, ONES,   1, 1, 64'h66);
        vt[22] = V("w0_status",    0, 1, 64'h18, 0,      1, 1, 1);
        vt[23] = V("w0_no_effect", 1, 0, 64'h18, 0,      1, 1, 1);
        vt[24] = V("w1c_status",   0, 1, 64'h18, ONES,   1, 1, 1);
        vt[25] = V("cleared",      1, 0, 64'h18, 0,      1, 1, 0);

        reset = 1'b1;
        bus.addr = 0; bus.wdata = 0; bus.mem_load_type = 0; bus.mem_store_type = 0;
        model_reset();
        #1;
        chk("rst_irq", 64'(irq), 0);
        do_reset();

        foreach (vt[i]) begin
            drive(vt[i].ld, vt[i].st, BASE + vt[i].off, vt[i].wd);
            chk({vt[i].nm, ".valid"}, 64'(bus.d_valid), 64'(vt[i].ev));
            chk({vt[i].nm, ".ready"}, 64'(bus.d_ready), 64'(vt[i].er));
            chk({vt[i].nm, ".rdata"}, bus.d_rdata, vt[i].erd);
            chk({vt[i].nm, ".irq"},   64'(irq), 0);
            model_step(vt[i].ld, vt[i].st, BASE + vt[i].off, vt[i].wd);
        end

        // Prescaler: PRESC=3 gives one tick every 4 cycles.
        do_reset();
        wr(64'h10, 64'h0301);
        repeat (40) cyc(3'd0, 3'd0, BASE, 64'd0);
        drive(3'd1, 3'd0, BASE, 64'd0);
        chk("presc_mtime", bus.d_rdata, 64'd10);
        chk("presc_irq", 64'(irq), 0);
        model_step(3'd1, 3'd0, BASE, 64'd0);

        // Pending/irq timing and W1C interplay.
        do_reset();
        wr(64'h08, 64'd5);
        wr(64'h10, 64'h0003);
        n = 0;
        while (m_mtime != 5 && n < 50) begin rd(64'h00); n++; end
        chk("reach5_bound", 64'(n < 50), 1);
        rd(64'h00);
        drive(3'd1, 3'd0, BASE + 64'h18, 0);
        chk("pend_at_5", bus.d_rdata, 1);
        chk("irq_not_yet", 64'(irq), 0);
        model_step(3'd1, 3'd0, BASE + 64'h18, 0);
        drive(3'd0, 3'd0, BASE, 0);
        chk("irq_rise", 64'(irq), 1);
        model_step(3'd0, 3'd0, BASE, 0);
        wr(64'h18, 64'd1);
        rd(64'h18);
        wr(64'h08, 64'd100);
        wr(64'h18, 64'd1);
        rd(64'h18);
        cyc(3'd0, 3'd0, BASE, 0);
        drive(3'd0, 3'd0, BASE, 0);
        chk("irq_cleared", 64'(irq), 0);
        model_step(3'd0, 3'd0, BASE, 0);

        // Periodic reload.
        do_reset();
        wr(64'h08, 64'd3);
        wr(64'h10, 64'h0007);
        for (int i = 0; i < 8; i++) begin
            drive(3'd1, 3'd0, BASE, 0);
            seq[i] = bus.d_rdata;
            model_step(3'd1, 3'd0, BASE, 0);
        end
        for (int i = 0; i < 8; i++) chk($sformatf("periodic[%0d]", i), seq[i], 64'(i % 4));
        drive(3'd1, 3'd0, BASE + 64'h18, 0);
        chk("periodic_pend", bus.d_rdata, 1);
        model_step(3'd1, 3'd0, BASE + 64'h18, 0);

        // Wrap and tick/write collision.
        do_reset();
        wr(64'h00, ONES);
        wr(64'h10, 64'h0001);
        rd(64'h00);
        drive(3'd1, 3'd0, BASE, 0);
        chk("wrap", bus.d_rdata, 0);
        model_step(3'd1, 3'd0, BASE, 0);
        wr(64'h00, 64'h1234);
        drive(3'd1, 3'd0, BASE, 0);
        chk("collision", bus.d_rdata, 64'h1234);
        model_step(3'd1, 3'd0, BASE, 0);

        // Asynchronous reset in the middle of a count with irq high.
        do_reset();
        wr(64'h08, 64'd2);
        wr(64'h10, 64'h0003);
        repeat (6) rd(64'h00);
        chk("pre_reset_irq", 64'(irq), 1);
        @(negedge clock);
        bus.addr = BASE; bus.mem_load_type = 1; bus.mem_store_type = 0;
        #1 reset = 1'b1;
        #1;
        chk("async_mtime", bus.d_rdata, 0);
        chk("async_irq", 64'(irq), 0);
        bus.addr = BASE + 64'h08;
        #1 chk("async_cmp", bus.d_rdata, ONES);
        bus.addr = BASE + 64'h18;
        #1 chk("async_status", bus.d_rdata, 0);
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        rd(64'h10);
        rd(64'h00);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            a  = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : BASE + 64'($urandom_range(0, 31));
            ld = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            st = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            wd = {$urandom, $urandom};
            case (a[4:3])
                2'd0, 2'd1: wd = 64'($urandom_range(0, 40));
                2'd2:       wd[15:8] = 8'($urandom_range(0, 3));
                default: ;
            endcase
            cyc(ld, st, a, wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
